// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a back-to-back frame shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int unsigned CLOCKS_PER_BIT  = 35,
  parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
  input  logic                       clock_input,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [7:0]                 write_data,
  output logic                       write_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned TW    = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                     state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [2:0]                 idx_q, idx_d;
  logic [7:0]                 shift_q, shift_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              count_d;
  logic [7:0]                 mem [DEPTH];
  logic                       push, pop, timer_last, fifo_has, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  // Next-state, FIFO handshake and next tx value
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    timer_last = (timer_q == TW'(CLOCKS_PER_BIT - 1));
    fifo_has   = (count != '0);
    push       = write_en && (count != CW'(DEPTH));

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (fifo_has) begin
          pop     = 1'b1;
          state_d = S_START;
          idx_d   = '0;
          shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^mem[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (timer_last) begin
          timer_d = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (timer_last) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_last) begin
          timer_d = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer_last) begin
          timer_d = '0;
          // Queued data chains straight into the next start bit
          if (fifo_has) begin
            pop     = 1'b1;
            state_d = S_START;
            idx_d   = '0;
            shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem[rd_ptr_q];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    count_d = count + CW'(push) - CW'(pop);
  end

  // State, pointers and registered outputs
  always_ff @(posedge clock_input) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count       <= '0;
      tx          <= 1'b1;
      write_ready <= 1'b1;
      busy        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      count       <= count_d;
      tx          <= tx_d;
      write_ready <= (count_d != CW'(DEPTH));
      busy        <= (state_d != S_IDLE) || (count_d != '0);
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clock_input) begin
    if (push && !reset) mem[wr_ptr_q] <= write_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a
// queue-based model of the serial waveform.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock_input = 1'b0;
  logic          reset = 1'b1;
  logic          write_en = 1'b0;
  logic [7:0]    write_data = '0;
  logic          write_ready, tx, busy;
  logic [AW:0]   count;

  int checks = 0;
  int passed = 0;

  logic [7:0] q[$];
  logic       fq[$];

  uart_tx_fifo #(.CLOCKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(AW)) dut (
    .clock_input(clock_input),
    .reset(reset),
    .write_en(write_en),
    .write_data(write_data),
    .write_ready(write_ready),
    .tx(tx),
    .busy(busy),
    .count(count)
  );

  always #5 clock_input = ~clock_input;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Expected line samples for one whole frame, one entry per clock cycle
  task automatic load_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) fq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) fq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) fq.push_back(^b);
`endif
    for (int c = 0; c < CPB; c++) fq.push_back(1'b1);
  endtask

  task automatic step(input logic rst, input logic we, input logic [7:0] d);
    logic full;
    reset = rst;
    write_en = we;
    write_data = d;
    @(posedge clock_input);
    if (rst) begin
      q.delete();
      fq.delete();
    end else begin
      full = (q.size() == DEPTH);
      if (fq.size() != 0) void'(fq.pop_front());
      if (fq.size() == 0 && q.size() != 0) load_frame(q.pop_front());
      if (we && !full) q.push_back(d);
    end
    #1;
    chk("tx", 32'(tx), 32'((fq.size() != 0) ? fq[0] : 1'b1));
    chk("count", 32'(count), 32'(q.size()));
    chk("write_ready", 32'(write_ready), 32'(q.size() != DEPTH));
    chk("busy", 32'(busy), 32'((fq.size() != 0) || (q.size() != 0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset for two cycles
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Single 0x55 frame, then line returns idle
    step(1'b0, 1'b1, 8'h55);
    idle(45);

    // Ten consecutive writes overfill the FIFO; 0x09 is dropped
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i));
    // Write on the edge where the first stop bit ends while still full
    idle(31);
    step(1'b0, 1'b1, 8'hEE);
    idle(340);
    chk("count_after_burst", 32'(count), 32'd0);

    // Reset mid-frame during data bit 3, then a clean 0xA5 frame
    step(1'b0, 1'b1, 8'h00);
    idle(16);
    step(1'b1, 1'b0, 8'h00);
    chk("tx_after_reset", 32'(tx), 32'd1);
    step(1'b0, 1'b1, 8'hA5);
    idle(45);

`ifdef UART_TX_PARITY_EN
    step(1'b0, 1'b1, 8'h07);
    idle(46);
    step(1'b0, 1'b1, 8'h03);
    idle(46);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      logic r, w;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 9) < 2);
      step(r, w, 8'($urandom));
    end
    // Burst to hit full with random data
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'($urandom));
    idle(500);
    chk("drained_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
